// File: rtl/adc_pkg.sv
// Shared types and constants for the MCP3202 joystick reader.
package adc_pkg;

  typedef enum logic [1:0] {
    CS_HI = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

  localparam logic [11:0] ADC_MID        = 12'd2048;
  localparam int          NUM_SCLK       = 17;
  localparam int          FIRST_DATA_BIT = 6;
  localparam int          BIT_W          = $clog2(NUM_SCLK + 1);

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // Command bit presented on DIN during SCLK period k; zero once the command is sent.
  function automatic logic cmd_bit(input logic [BIT_W-1:0] k, input logic ch);
    logic b;
    b = 1'b0;
    case (k)
      BIT_W'(1): b = CMD_START;
      BIT_W'(2): b = CMD_SGL;
      BIT_W'(3): b = ch;
      BIT_W'(4): b = CMD_MSBF;
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_joystick_reader_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_joystick_reader.sv
// SPI master that alternately converts MCP3202 channels 0 and 1 and
// publishes the latest joystick readings as CH0/CH1.
module adc_joystick_reader
  import adc_pkg::*;
#(
  parameter int SCLK_HALF = 13,
  parameter int CS_SETUP  = 3,
  parameter int CS_HIGH   = 13
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  output logic [11:0] CH0,
  output logic [11:0] CH1,
  output logic        sample_valid,
  output logic        sample_ch
);

  localparam int PERIOD    = 2 * SCLK_HALF;
  localparam int CNT_MAX_A = (PERIOD > CS_HIGH) ? PERIOD - 1 : CS_HIGH - 1;
  localparam int CNT_MAX   = (CNT_MAX_A > CS_SETUP - 1) ? CNT_MAX_A : CS_SETUP - 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HIGH_M1   = CNT_W'(CS_HIGH - 1);
  localparam logic [CNT_W-1:0] SETUP_M1  = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(SCLK_HALF);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NUM_SCLK);
  localparam logic [BIT_W-1:0] FIRST_BIT = BIT_W'(FIRST_DATA_BIT);

  adc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ch_q, ch_d;
  logic [11:0]      shreg_q, shreg_d;
  logic [11:0]      ch0_q, ch0_d;
  logic [11:0]      ch1_q, ch1_d;
  logic             valid_q, valid_d;
  logic             sample_ch_q, sample_ch_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             miso_s;

  sync2 #(.W(1)) u_miso_sync (
    .clk (clk25),
    .rst (rst),
    .d   (adc_miso),
    .q   (miso_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    ch_d        = ch_q;
    shreg_d     = shreg_q;
    ch0_d       = ch0_q;
    ch1_d       = ch1_q;
    valid_d     = 1'b0;
    sample_ch_d = sample_ch_q;

    case (state_q)
      CS_HI: begin
        if (cnt_q == HIGH_M1) begin
          if (en) begin
            state_d = SETUP;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_M1) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // Sample on the last high cycle; the null bit and command slots are skipped.
        if (cnt_q == HALF_M1 && bit_q >= FIRST_BIT) begin
          shreg_d = {shreg_q[10:0], miso_s};
        end
        if (cnt_q == PERIOD_M1) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d     = DONE;
            valid_d     = 1'b1;
            sample_ch_d = ch_q;
            if (ch_q) ch1_d = shreg_q;
            else      ch0_d = shreg_q;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = CS_HI;
        cnt_d   = '0;
        ch_d    = ~ch_q;
      end
      default: begin
        state_d = CS_HI;
        cnt_d   = '0;
      end
    endcase

    // Pin values are derived from the next state so they are registered with it.
    cs_n_d = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    case (state_d)
      SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = CMD_START;
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = (cnt_d < HALF);
        mosi_d = (cnt_d < HALF) ? cmd_bit(bit_d, ch_d) : cmd_bit(bit_d + BIT_W'(1), ch_d);
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q     <= CS_HI;
      cnt_q       <= '0;
      bit_q       <= '0;
      ch_q        <= 1'b0;
      shreg_q     <= '0;
      ch0_q       <= ADC_MID;
      ch1_q       <= ADC_MID;
      valid_q     <= 1'b0;
      sample_ch_q <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      ch_q        <= ch_d;
      shreg_q     <= shreg_d;
      ch0_q       <= ch0_d;
      ch1_q       <= ch1_d;
      valid_q     <= valid_d;
      sample_ch_q <= sample_ch_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_mosi     = mosi_q;
  assign CH0          = ch0_q;
  assign CH1          = ch1_q;
  assign sample_valid = valid_q;
  assign sample_ch    = sample_ch_q;

endmodule

// File: doc/adc_joystick_reader.md
Name: adc_joystick_reader

Overview:
SPI master for the MCP3202 2-channel 12-bit ADC wired to the analog joystick. It continuously alternates conversions on channel 0 and channel 1, then presents the results as registered CH0/CH1 words. The drawing stage downstream samples these words once per frame to steer the sprite/reticle. The block runs entirely in the clk25 domain and drives the ADC pins directly.

Parameters:
SCLK_HALF, 13, clk25 cycles per SCLK half-period (SCLK ≈ 961 kHz; must be ≥ 4).
CS_SETUP, 3, clk25 cycles from cs_n falling to the first SCLK rising edge (≥ 100 ns).
CS_HIGH, 13, clk25 cycles cs_n is held high between conversions (≥ 500 ns).

Ports:
clk25  in  1  25 MHz system clock
rst  in  1  reset, synchronous, active-high
en  in  1  1 = keep converting; 0 = finish the current conversion, then stay idle with cs_n high
adc_miso  in  1  ADC DOUT (asynchronous)
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  SPI clock (mode 0,0; idles low)
adc_mosi  out  1  ADC DIN
CH0  out  12  latest channel-0 result (joystick vertical axis)
CH1  out  12  latest channel-1 result (joystick horizontal axis)
sample_valid  out  1  one-cycle pulse when CH0 or CH1 is updated
sample_ch  out  1  channel written on the sample_valid cycle

Behaviour:
- Reset: while rst=1, and in the first cycle after it, the outputs are cs_n=1, sclk=0, mosi=0, CH0=CH1=12'd2048 (joystick neutral, so the drawing stage computes dx=dy=0), sample_valid=0, sample_ch=0, next channel=0, FSM=CS_HI with the counter cleared. Reset asserted during a conversion aborts it on the next edge. No partial result is written.
- adc_miso passes through a 2-FF synchronizer before it is used.
- FSM states: CS_HI -> SETUP -> SHIFT -> DONE -> CS_HI.
- CS_HI: cs_n=1, sclk=0, mosi=0. After CS_HIGH cycles, the FSM goes to SETUP only if en=1. Otherwise it stays in CS_HI.
- SETUP: cs_n=0, sclk=0, mosi=start bit (1). Lasts CS_SETUP cycles.
- SHIFT: covers 17 SCLK periods. Each period is SCLK_HALF cycles with sclk=1, then SCLK_HALF cycles with sclk=0. The bit index k runs from 1 to 17.
- MOSI bits k=1..4 are 1 (start), 1 (SGL), ch (ODD), 1 (MSBF). MOSI changes only on the first cycle of each low phase, which presents bit k+1. For k≥5, mosi=0.
- MISO is sampled from the synchronized signal on the last high cycle of each period.
- k=5 is the null bit and is discarded. k=6..17 shift in B11..B0, MSB first, into a 12-bit shift register.
- DONE: lasts 1 cycle with cs_n=1.
  - If ch=0, CH0 <= shift register; otherwise CH1 <= shift register.
  - sample_valid=1 and sample_ch=ch for this cycle only.
  - ch toggles.
- Conversion period is CS_HIGH + CS_SETUP + 34*SCLK_HALF + 1 cycles (459 with defaults).
- sample_valid rises on the last cycle of each period.
- CH0/CH1 change only in DONE, atomically across all 12 bits. They hold their value otherwise.
- en deasserted mid-conversion has no effect until the FSM reaches CS_HI. en reasserted restarts with the saved ch. Channel order is never reset by en.
- Counters are sized by $clog2 of their maximum count. The bit counter saturates at 17 and never wraps.

Decomposition:
- adc_pkg holds:
  - the state enum (CS_HI, SETUP, SHIFT, DONE);
  - ADC_MID = 12'd2048;
  - NUM_SCLK = 17;
  - FIRST_DATA_BIT = 6;
  - the command-bit constants.
- One natural sub-module is sync2, a generic 2-FF synchronizer used for adc_miso.

Test Plan:
- Reset check: hold rst for 5 cycles -> CH0=CH1=0x800, cs_n=1, sclk=0, sample_valid=0 throughout, and for 1 cycle after.
- Single conversion: en=1, the ADC model returns 0xABC for ch0 -> MOSI decodes 1,1,0,1; there are exactly 17 sclk rising edges while cs_n=0; sample_valid pulses on cycle 459 after reset release with sample_ch=0; CH0=0xABC; CH1 unchanged at 0x800.
- Alternation: the model returns ch0=0x123 and ch1=0xFED -> the second conversion has ODD=1 and gives CH1=0xFED; the third conversion has ODD=0; pulses are spaced exactly 459 cycles apart.
- Extremes: the model returns 0x000, then 0xFFF -> exact values are captured and no bit slips; the null-bit value driven as 1 does not leak into B11.
- en gating: deassert en at cycle 200 of conversion 2 -> that conversion completes and updates CH1; cs_n then stays high indefinitely. Reasserting en starts a conversion with ODD=0 after CS_HIGH cycles.
- Reset mid-SHIFT: assert rst at bit k=9 -> cs_n=1 and sclk=0 on the next edge; CH0/CH1 return to 0x800; no sample_valid pulse; the next conversion is channel 0.
